bp_be_decode_queue: RTL and testbench

- Registered, parametrised decode stage between the FE issue interface and the BE calculator/scheduler.
- Decodes incoming RV64I instructions, plus RV64M when m_ext_p=1, into bp_be_decode_s control words.
- Buffers decoded words in a depth_p-entry FIFO with valid/ready handshakes on both sides.
- Supports nop insertion, pipeline flush, and a saturating illegal-instruction counter for debug/CSR visibility.

---
 rtl/bp_be_decode_queue.sv | 273 +++++++++++++++++++++++++++
 tb/tb_bp_be_decode_queue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_decode_queue.sv
// Decode stage between FE issue and BE scheduling: RV64I/M decoder feeding a
// depth_p-entry FIFO of decoded control words, with nop injection, flush and an illegal counter.

package bp_be_decode_queue_pkg;

    typedef struct packed {
        logic       instr_v;
        logic       be_nop_v;
        logic       pipe_comp_v;
        logic       pipe_int_v;
        logic       pipe_mem_v;
        logic       pipe_mul_v;
        logic       irf_w_v;
        logic       dcache_r_v;
        logic       dcache_w_v;
        logic       csr_v;
        logic       mret_v;
        logic       opw_v;
        logic [2:0] funct3;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rd_addr;
    } bp_be_decode_s;

    localparam int unsigned decode_width_lp = $bits(bp_be_decode_s);

    localparam logic [6:0] opc_load_c     = 7'b0000011;
    localparam logic [6:0] opc_misc_mem_c = 7'b0001111;
    localparam logic [6:0] opc_op_imm_c   = 7'b0010011;
    localparam logic [6:0] opc_auipc_c    = 7'b0010111;
    localparam logic [6:0] opc_op_imm32_c = 7'b0011011;
    localparam logic [6:0] opc_store_c    = 7'b0100011;
    localparam logic [6:0] opc_op_c       = 7'b0110011;
    localparam logic [6:0] opc_lui_c      = 7'b0110111;
    localparam logic [6:0] opc_op32_c     = 7'b0111011;
    localparam logic [6:0] opc_branch_c   = 7'b1100011;
    localparam logic [6:0] opc_jalr_c     = 7'b1100111;
    localparam logic [6:0] opc_jal_c      = 7'b1101111;
    localparam logic [6:0] opc_system_c   = 7'b1110011;

    localparam logic [6:0]  f7_base_c = 7'b0000000;
    localparam logic [6:0]  f7_alt_c  = 7'b0100000;
    localparam logic [6:0]  f7_mul_c  = 7'b0000001;
    localparam logic [31:0] mret_c    = 32'h3020_0073;

    // CSR addresses implemented by the BE CSR file
    function automatic logic csr_supported(input logic [11:0] addr);
        logic ok;
        case (addr)
            12'h300, 12'h301, 12'h304, 12'h305,
            12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
            12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'hF14: ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

module bp_be_decode_queue
    import bp_be_decode_queue_pkg::*;
#(
    parameter int unsigned vaddr_width_p       = 39,
    parameter int unsigned depth_p             = 4,
    parameter bit          m_ext_p             = 1'b1,
    parameter int unsigned illegal_cnt_width_p = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           instr_v_i,
    input  logic [31:0]                    instr_i,
    input  logic [vaddr_width_p-1:0]       pc_i,
    input  logic                           nop_v_i,
    output logic                           instr_ready_o,
    input  logic                           flush_i,
    output logic                           decode_v_o,
    output logic [decode_width_lp-1:0]     decode_o,
    output logic [vaddr_width_p-1:0]       pc_o,
    output logic                           illegal_o,
    input  logic                           decode_yumi_i,
    output logic [illegal_cnt_width_p-1:0] illegal_cnt_o,
    output logic                           empty_o
);

    localparam int unsigned ptr_width_lp = $clog2(depth_p);
    localparam int unsigned cnt_width_lp = ptr_width_lp + 1;

    logic [6:0]  w_opcode;
    logic [6:0]  w_funct7;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic        w_rd_nz;
    logic        w_legal;
    logic        w_mul;
    bp_be_decode_s w_dec;
    bp_be_decode_s w_entry;
    logic        w_entry_ill;

    logic [ptr_width_lp-1:0]        r_wptr;
    logic [ptr_width_lp-1:0]        r_rptr;
    logic [cnt_width_lp-1:0]        r_count;
    logic [illegal_cnt_width_p-1:0] r_illegal_cnt;
    logic [decode_width_lp-1:0]     r_mem_dec [depth_p];
    logic [vaddr_width_p-1:0]       r_mem_pc  [depth_p];
    logic [depth_p-1:0]             r_mem_ill;

    logic w_enq;
    logic w_deq;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];
    assign w_rd     = instr_i[11:7];
    assign w_rd_nz  = (w_rd != 5'd0);

    // Instruction decoder: classifies the opcode and checks encoding legality
    always_comb begin
        w_dec   = '0;
        w_legal = 1'b0;
        w_mul   = 1'b0;
        case (w_opcode)
            opc_op_c: begin
                w_mul   = (w_funct7 == f7_mul_c);
                w_legal = (w_funct7 == f7_base_c)
                        || ((w_funct7 == f7_alt_c) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)))
                        || (w_mul && m_ext_p);
                w_dec.pipe_int_v = ~w_mul;
                w_dec.pipe_mul_v = w_mul;
                w_dec.irf_w_v    = w_rd_nz;
            end
            opc_op32_c: begin
                w_mul   = (w_funct7 == f7_mul_c);
                w_legal = ((w_funct7 == f7_base_c)
                           && ((w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b101)))
                        || ((w_funct7 == f7_alt_c) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)))
                        || (w_mul && m_ext_p && ((w_funct3 == 3'b000) || w_funct3[2]));
                w_dec.pipe_int_v = ~w_mul;
                w_dec.pipe_mul_v = w_mul;
                w_dec.irf_w_v    = w_rd_nz;
                w_dec.opw_v      = 1'b1;
            end
            opc_op_imm_c: begin
                if (w_funct3 == 3'b001) begin
                    w_legal = (instr_i[31:26] == 6'b000000);
                end else if (w_funct3 == 3'b101) begin
                    w_legal = (instr_i[31:26] == 6'b000000) || (instr_i[31:26] == 6'b010000);
                end else begin
                    w_legal = 1'b1;
                end
                w_dec.pipe_int_v = 1'b1;
                w_dec.irf_w_v    = w_rd_nz;
            end
            opc_op_imm32_c: begin
                w_legal = (w_funct3 == 3'b000)
                        || ((w_funct3 == 3'b001) && (w_funct7 == f7_base_c))
                        || ((w_funct3 == 3'b101) && ((w_funct7 == f7_base_c) || (w_funct7 == f7_alt_c)));
                w_dec.pipe_int_v = 1'b1;
                w_dec.irf_w_v    = w_rd_nz;
                w_dec.opw_v      = 1'b1;
            end
            opc_lui_c, opc_auipc_c, opc_jal_c: begin
                w_legal          = 1'b1;
                w_dec.pipe_int_v = 1'b1;
                w_dec.irf_w_v    = w_rd_nz;
            end
            opc_jalr_c: begin
                w_legal          = (w_funct3 == 3'b000);
                w_dec.pipe_int_v = 1'b1;
                w_dec.irf_w_v    = w_rd_nz;
            end
            opc_branch_c: begin
                w_legal          = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
                w_dec.pipe_int_v = 1'b1;
            end
            opc_load_c: begin
                w_legal          = (w_funct3 != 3'b111);
                w_dec.pipe_mem_v = 1'b1;
                w_dec.dcache_r_v = 1'b1;
                w_dec.irf_w_v    = w_rd_nz;
            end
            opc_store_c: begin
                w_legal          = ~w_funct3[2];
                w_dec.pipe_mem_v = 1'b1;
                w_dec.dcache_w_v = 1'b1;
            end
            opc_misc_mem_c: begin
                w_legal          = (w_funct3 == 3'b000) || (w_funct3 == 3'b001);
                w_dec.pipe_int_v = 1'b1;
            end
            opc_system_c: begin
                if (instr_i == mret_c) begin
                    w_legal          = 1'b1;
                    w_dec.pipe_mem_v = 1'b1;
                    w_dec.mret_v     = 1'b1;
                end else if ((w_funct3[1:0] != 2'b00) && csr_supported(instr_i[31:20])) begin
                    w_legal          = 1'b1;
                    w_dec.pipe_mem_v = 1'b1;
                    w_dec.csr_v      = 1'b1;
                    w_dec.irf_w_v    = w_rd_nz;
                end
            end
            default: w_legal = 1'b0;
        endcase
        w_dec.instr_v  = 1'b1;
        w_dec.funct3   = w_funct3;
        w_dec.rs1_addr = instr_i[19:15];
        w_dec.rs2_addr = instr_i[24:20];
        w_dec.rd_addr  = w_rd;
    end

    // Final entry: nop overrides decode, illegal collapses to an all-zero word
    always_comb begin
        w_entry     = '0;
        w_entry_ill = 1'b0;
        if (nop_v_i) begin
            w_entry.pipe_comp_v = 1'b1;
            w_entry.be_nop_v    = 1'b1;
        end else if (w_legal) begin
            w_entry = w_dec;
        end else begin
            w_entry_ill = 1'b1;
        end
    end

    assign instr_ready_o = (r_count < cnt_width_lp'(depth_p)) | decode_yumi_i;
    assign w_enq         = instr_v_i & instr_ready_o & ~flush_i;
    assign w_deq         = decode_yumi_i & decode_v_o & ~flush_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + ptr_width_lp'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + ptr_width_lp'(1);
            end
            r_count <= r_count + cnt_width_lp'(w_enq) - cnt_width_lp'(w_deq);
        end
    end

    // Saturating debug counter; survives flush, only reset clears it
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_illegal_cnt <= '0;
        end else if (w_enq && w_entry_ill && (r_illegal_cnt != '1)) begin
            r_illegal_cnt <= r_illegal_cnt + illegal_cnt_width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem_dec[r_wptr] <= w_entry;
            r_mem_pc[r_wptr]  <= pc_i;
            r_mem_ill[r_wptr] <= w_entry_ill;
        end
    end

    assign decode_v_o    = (r_count != '0);
    assign empty_o       = (r_count == '0);
    assign decode_o      = decode_v_o ? r_mem_dec[r_rptr] : '0;
    assign pc_o          = decode_v_o ? r_mem_pc[r_rptr] : '0;
    assign illegal_o     = decode_v_o & r_mem_ill[r_rptr];
    assign illegal_cnt_o = r_illegal_cnt;

endmodule

// File: tb/tb_bp_be_decode_queue.sv
// Self-checking bench for bp_be_decode_queue: decode vector table plus
// backpressure, flush, saturation, RV64M-off and async reset sequences.

module tb_bp_be_decode_queue;
    import bp_be_decode_queue_pkg::*;

    localparam int unsigned VA    = 39;
    localparam int          DEPTH = 4;

    // f = {int, mem, mul, irf_w, dcache_r, dcache_w, opw, csr, mret}
    typedef struct packed {
        logic [31:0] instr;
        logic        nop;
        logic        ill;
        logic [8:0]  f;
    } vec_t;

    typedef struct packed {
        bp_be_decode_s   dec;
        logic [VA-1:0]   pc;
        logic            ill;
    } sb_t;

    logic                       clk_i;
    logic                       reset_n_i;
    logic                       instr_v_i;
    logic [31:0]                instr_i;
    logic [VA-1:0]              pc_i;
    logic                       nop_v_i;
    logic                       flush_i;
    logic                       decode_yumi_i;
    logic                       instr_ready_o, nm_ready;
    logic                       decode_v_o, nm_v;
    logic [decode_width_lp-1:0] decode_o, nm_dec;
    logic [VA-1:0]              pc_o, nm_pc;
    logic                       illegal_o, nm_ill;
    logic [7:0]                 illegal_cnt_o, nm_cnt;
    logic                       empty_o, nm_empty;

    int     n_cmp = 0;
    int     n_bad = 0;
    sb_t    sb[$];
    logic [7:0] m_ill = 8'd0;
    vec_t   tab[23];
    vec_t   idle = '0;
    vec_t   ill0;
    bp_be_decode_s d;

    bp_be_decode_queue #(.vaddr_width_p(VA), .depth_p(DEPTH), .m_ext_p(1'b1), .illegal_cnt_width_p(8)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .instr_v_i(instr_v_i), .instr_i(instr_i),
        .pc_i(pc_i), .nop_v_i(nop_v_i), .instr_ready_o(instr_ready_o), .flush_i(flush_i),
        .decode_v_o(decode_v_o), .decode_o(decode_o), .pc_o(pc_o), .illegal_o(illegal_o),
        .decode_yumi_i(decode_yumi_i), .illegal_cnt_o(illegal_cnt_o), .empty_o(empty_o));

    bp_be_decode_queue #(.vaddr_width_p(VA), .depth_p(DEPTH), .m_ext_p(1'b0), .illegal_cnt_width_p(8)) dut_nm (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .instr_v_i(instr_v_i), .instr_i(instr_i),
        .pc_i(pc_i), .nop_v_i(nop_v_i), .instr_ready_o(nm_ready), .flush_i(flush_i),
        .decode_v_o(nm_v), .decode_o(nm_dec), .pc_o(nm_pc), .illegal_o(nm_ill),
        .decode_yumi_i(decode_yumi_i), .illegal_cnt_o(nm_cnt), .empty_o(nm_empty));

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic nop, input logic ill, input logic [8:0] f);
        vec_t v;
        v.instr = instr;
        v.nop   = nop;
        v.ill   = ill;
        v.f     = f;
        return v;
    endfunction

    function automatic bp_be_decode_s mk_exp(input vec_t v);
        bp_be_decode_s e;
        e = '0;
        if (v.nop) begin
            e.pipe_comp_v = 1'b1;
            e.be_nop_v    = 1'b1;
        end else if (!v.ill) begin
            e.instr_v    = 1'b1;
            e.pipe_int_v = v.f[8];
            e.pipe_mem_v = v.f[7];
            e.pipe_mul_v = v.f[6];
            e.irf_w_v    = v.f[5];
            e.dcache_r_v = v.f[4];
            e.dcache_w_v = v.f[3];
            e.opw_v      = v.f[2];
            e.csr_v      = v.f[1];
            e.mret_v     = v.f[0];
            e.funct3     = v.instr[14:12];
            e.rs1_addr   = v.instr[19:15];
            e.rs2_addr   = v.instr[24:20];
            e.rd_addr    = v.instr[11:7];
        end
        return e;
    endfunction

    // One clock: drive, check pre-edge state against the model, then update the model
    task automatic cycle(input logic v, input vec_t x, input logic [VA-1:0] pc, input logic yumi, input logic fl);
        logic exp_rdy;
        sb_t  e;
        sb_t  n;
        instr_v_i     = v;
        instr_i       = x.instr;
        pc_i          = pc;
        nop_v_i       = x.nop;
        decode_yumi_i = yumi;
        flush_i       = fl;
        #2;
        exp_rdy = (sb.size() < DEPTH) || yumi;
        chk("ready", 64'(instr_ready_o), 64'(exp_rdy));
        chk("valid", 64'(decode_v_o), 64'(sb.size() != 0));
        chk("empty", 64'(empty_o), 64'(sb.size() == 0));
        chk("ill_cnt", 64'(illegal_cnt_o), 64'(m_ill));
        if (sb.size() == 0) begin
            chk("idle_dec", 64'(decode_o), 64'(0));
            chk("idle_pc", 64'(pc_o), 64'(0));
        end
        if (yumi) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL yumi_on_empty: decode_v_o=%0b required 1", decode_v_o);
            end else begin
                e = sb[0];
                chk("head_dec", 64'(decode_o), 64'(e.dec));
                chk("head_pc", 64'(pc_o), 64'(e.pc));
                chk("head_ill", 64'(illegal_o), 64'(e.ill));
            end
        end
        @(posedge clk_i);
        if (fl) begin
            sb.delete();
        end else begin
            if (yumi && sb.size() != 0) void'(sb.pop_front());
            if (v && exp_rdy) begin
                n.dec = mk_exp(x);
                n.pc  = pc;
                n.ill = x.ill & ~x.nop;
                sb.push_back(n);
                if (n.ill && m_ill != 8'hFF) m_ill++;
            end
        end
        #1;
        instr_v_i     = 1'b0;
        nop_v_i       = 1'b0;
        decode_yumi_i = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic drain();
        while (sb.size() != 0) cycle(1'b0, idle, '0, 1'b1, 1'b0);
    endtask

    // Async reset: outputs must clear before any clock edge
    task automatic do_reset();
        reset_n_i = 1'b0;
        #1;
        chk("rst_valid", 64'(decode_v_o), 64'(0));
        chk("rst_ready", 64'(instr_ready_o), 64'(1));
        chk("rst_empty", 64'(empty_o), 64'(1));
        chk("rst_ill", 64'(illegal_o), 64'(0));
        chk("rst_cnt", 64'(illegal_cnt_o), 64'(0));
        chk("rst_dec", 64'(decode_o), 64'(0));
        chk("rst_pc", 64'(pc_o), 64'(0));
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        sb.delete();
        m_ill = 8'd0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        tab[0]  = mk(32'h002081B3, 1'b0, 1'b0, 9'b100100000); // ADD
        tab[1]  = mk(32'h402081B3, 1'b0, 1'b0, 9'b100100000); // SUB
        tab[2]  = mk(32'h002081BB, 1'b0, 1'b0, 9'b100100100); // ADDW
        tab[3]  = mk(32'h0010809B, 1'b0, 1'b0, 9'b100100100); // ADDIW
        tab[4]  = mk(32'h123452B7, 1'b0, 1'b0, 9'b100100000); // LUI
        tab[5]  = mk(32'h00000297, 1'b0, 1'b0, 9'b100100000); // AUIPC
        tab[6]  = mk(32'h000000EF, 1'b0, 1'b0, 9'b100100000); // JAL
        tab[7]  = mk(32'h00008067, 1'b0, 1'b0, 9'b100000000); // JALR x0
        tab[8]  = mk(32'h00208463, 1'b0, 1'b0, 9'b100000000); // BEQ
        tab[9]  = mk(32'h0000B303, 1'b0, 1'b0, 9'b010110000); // LD
        tab[10] = mk(32'h0020B423, 1'b0, 1'b0, 9'b010001000); // SD
        tab[11] = mk(32'h0FF0000F, 1'b0, 1'b0, 9'b100000000); // FENCE
        tab[12] = mk(32'h300110F3, 1'b0, 1'b0, 9'b010100010); // CSRRW mstatus
        tab[13] = mk(32'h7C0020F3, 1'b0, 1'b1, 9'b000000000); // unsupported CSR
        tab[14] = mk(32'h30200073, 1'b0, 1'b0, 9'b010000001); // MRET
        tab[15] = mk(32'h022081B3, 1'b0, 1'b0, 9'b001100000); // MUL
        tab[16] = mk(32'h0220C1BB, 1'b0, 1'b0, 9'b001100100); // DIVW
        tab[17] = mk(32'h00000000, 1'b0, 1'b1, 9'b000000000); // all-zero
        tab[18] = mk(32'hFFFFFFFF, 1'b1, 1'b0, 9'b000000000); // nop over garbage
        tab[19] = mk(32'h03F09093, 1'b0, 1'b0, 9'b100100000); // SLLI shamt 63
        tab[20] = mk(32'h4010D093, 1'b0, 1'b0, 9'b100100000); // SRAI
        tab[21] = mk(32'h402091B3, 1'b0, 1'b1, 9'b000000000); // SLL with alt funct7
        tab[22] = mk(32'h0000F303, 1'b0, 1'b1, 9'b000000000); // LOAD funct3 111
        ill0    = tab[17];

        reset_n_i     = 1'b1;
        instr_v_i     = 1'b0;
        instr_i       = '0;
        pc_i          = '0;
        nop_v_i       = 1'b0;
        flush_i       = 1'b0;
        decode_yumi_i = 1'b0;
        #1;
        do_reset();

        // ADDI x1,x0,5 visible one cycle after enqueue
        cycle(1'b1, mk(32'h00500093, 1'b0, 1'b0, 9'b100100000), 39'h80000000, 1'b0, 1'b0);
        #1;
        d = bp_be_decode_s'(decode_o);
        chk("addi_v", 64'(decode_v_o), 64'(1));
        chk("addi_pc", 64'(pc_o), 64'h80000000);
        chk("addi_int", 64'(d.pipe_int_v), 64'(1));
        chk("addi_irf", 64'(d.irf_w_v), 64'(1));
        chk("addi_rd", 64'(d.rd_addr), 64'(1));
        chk("addi_ill", 64'(illegal_o), 64'(0));
        cycle(1'b0, idle, '0, 1'b1, 1'b0);

        // Decode table, streamed with concurrent dequeue
        for (int i = 0; i < 23; i++)
            cycle(1'b1, tab[i], 39'h80000000 + VA'(4 * i), sb.size() != 0, 1'b0);
        drain();

        // Fill, refuse when full, accept with yumi, order across wrap
        for (int i = 0; i < 4; i++)
            cycle(1'b1, tab[i], 39'h100 + VA'(4 * i), 1'b0, 1'b0);
        cycle(1'b1, tab[4], 39'h200, 1'b0, 1'b0);
        cycle(1'b1, tab[5], 39'h110, 1'b1, 1'b0);
        cycle(1'b0, idle, '0, 1'b0, 1'b0);
        drain();

        // Flush with a concurrent enqueue and yumi
        cycle(1'b1, tab[0], 39'h300, 1'b0, 1'b0);
        cycle(1'b1, ill0, 39'h304, 1'b0, 1'b0);
        cycle(1'b1, tab[9], 39'h308, 1'b0, 1'b0);
        cycle(1'b1, tab[1], 39'h30C, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, idle, '0, 1'b0, 1'b0);

        // Counter saturation
        for (int i = 0; i < 300; i++)
            cycle(1'b1, ill0, 39'h1000 + VA'(4 * i), sb.size() != 0, 1'b0);
        drain();
        chk("cnt_sat", 64'(illegal_cnt_o), 64'd255);

        // MUL with and without RV64M
        do_reset();
        cycle(1'b1, tab[15], 39'h400, 1'b0, 1'b0);
        #1;
        d = bp_be_decode_s'(decode_o);
        chk("mul_pipe", 64'(d.pipe_mul_v), 64'(1));
        chk("nm_v", 64'(nm_v), 64'(1));
        chk("nm_ill", 64'(nm_ill), 64'(1));
        chk("nm_dec", 64'(nm_dec), 64'(0));
        chk("nm_cnt", 64'(nm_cnt), 64'(1));
        drain();

        // Nop over an illegal encoding, then async reset with a loaded queue
        cycle(1'b1, tab[18], 39'h500, 1'b0, 1'b0);
        #1;
        d = bp_be_decode_s'(decode_o);
        chk("nop_comp", 64'(d.pipe_comp_v), 64'(1));
        chk("nop_be", 64'(d.be_nop_v), 64'(1));
        chk("nop_ill", 64'(illegal_o), 64'(0));
        chk("nop_cnt", 64'(illegal_cnt_o), 64'(0));
        cycle(1'b1, ill0, 39'h504, 1'b0, 1'b0);
        cycle(1'b1, tab[0], 39'h508, 1'b0, 1'b0);
        do_reset();
        cycle(1'b0, idle, '0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
